xorshift_32_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one xorshift-32 generator among `NUM_REQ` requesters. The generator state advances only when a draw is granted, so every requester receives a distinct word of the sequence. The block also handles seeding and a post-seed warm-up, and masks each response to the requester's range. It sits between the PRNG datapath and consumers such as dither, noise-injection and randomized-schedule blocks.

---
 rtl/xorshift_32_share_ctrl_pkg.sv | 21 ++
 rtl/xorshift_32_share_ctrl_rr_arbiter.sv | 38 +++
 rtl/xorshift_32_share_ctrl.sv | 122 ++++++++++++
 tb/tb_xorshift_32_share_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/xorshift_32_share_ctrl_pkg.sv
// Shared xorshift-32 definitions: step function, default seed and the
// sequencer state encoding used by the generator and the share controller.
package xorshift_pkg;

  localparam logic [31:0] XS_DEFAULT_SEED = 32'h2545_F491;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } xs_ctrl_state_t;

  // One generator step; a nonzero input always yields a nonzero output.
  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 5'd13);
    t = t ^ (t >> 5'd17);
    t = t ^ (t << 5'd5);
    return t;
  endfunction

endpackage

// File: rtl/xorshift_32_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), one-hot plus encoded index. The pointer lives in the caller.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found_s;
  int               idx_s;
  logic [IDX_W-1:0] idx_w_s;

  // Scan requesters starting at the pointer and take the first one pending.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    idx_w_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s   = (int'(ptr) + k) % N;
      idx_w_s = IDX_W'(idx_s);
      if (enable && !found_s && req[idx_w_s]) begin
        grant[idx_w_s] = 1'b1;
        grant_idx      = idx_w_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/xorshift_32_share_ctrl.sv
// Shares one xorshift-32 generator among NUM_REQ requesters: seeding,
// post-seed warm-up, round-robin draw arbitration and per-requester masking.
module xorshift_32_share_ctrl
  import xorshift_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          WARMUP_CYCLES = 16,
  parameter logic [31:0] DEFAULT_SEED  = XS_DEFAULT_SEED
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Seed_load,
  input  logic [31:0]             Seed_value,
  input  logic [NUM_REQ-1:0]      Req_valid,
  input  logic [NUM_REQ*32-1:0]   Req_mask,
  output logic [NUM_REQ-1:0]      Req_ready,
  output logic [NUM_REQ-1:0]      Rsp_valid,
  output logic [31:0]             Rsp_data,
  output logic                    Busy
);

  localparam int             IDX_W      = $clog2(NUM_REQ);
  localparam logic [7:0]     WARMUP_CNT = 8'(WARMUP_CYCLES);
  localparam xs_ctrl_state_t INIT_FSM   = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

  logic [31:0]        state_r, state_next_s, stepped_s;
  xs_ctrl_state_t     fsm_r, fsm_next_s;
  logic [7:0]         cnt_r, cnt_next_s;
  logic [IDX_W-1:0]   ptr_r, ptr_next_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_next_s;
  logic [31:0]        rsp_data_r, rsp_data_next_s;
  logic               busy_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               arb_en_s;

  assign stepped_s = xorshift32_step(state_r);
  // A seed load pre-empts any draw in the same cycle.
  assign arb_en_s  = (fsm_r == RUN) && !Seed_load;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (Req_valid),
    .ptr       (ptr_r),
    .enable    (arb_en_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Next-state logic for generator state, sequencer, pointer and response.
  always_comb begin
    state_next_s     = state_r;
    fsm_next_s       = fsm_r;
    cnt_next_s       = cnt_r;
    ptr_next_s       = ptr_r;
    rsp_valid_next_s = '0;
    rsp_data_next_s  = rsp_data_r;
    if (Seed_load) begin
      state_next_s = (Seed_value == 32'h0000_0000) ? DEFAULT_SEED : Seed_value;
      cnt_next_s   = WARMUP_CNT;
      fsm_next_s   = INIT_FSM;
    end else begin
      case (fsm_r)
        WARMUP: begin
          state_next_s = stepped_s;
          if (cnt_r <= 8'd1) begin
            cnt_next_s = 8'd0;
            fsm_next_s = RUN;
          end else begin
            cnt_next_s = cnt_r - 8'd1;
            fsm_next_s = WARMUP;
          end
        end
        RUN: begin
          if (|grant_s) begin
            state_next_s     = stepped_s;
            ptr_next_s       = (int'(grant_idx_s) == NUM_REQ - 1) ? IDX_W'(0)
                                                                  : grant_idx_s + IDX_W'(1);
            rsp_valid_next_s = grant_s;
            rsp_data_next_s  = stepped_s & Req_mask[32*int'(grant_idx_s) +: 32];
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s = DEFAULT_SEED;
          cnt_next_s   = WARMUP_CNT;
          fsm_next_s   = INIT_FSM;
        end
      endcase
    end
  end

  // Register all state; reset also kills any response in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= DEFAULT_SEED;
      fsm_r       <= INIT_FSM;
      cnt_r       <= WARMUP_CNT;
      ptr_r       <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= 32'h0000_0000;
      busy_r      <= (INIT_FSM != RUN);
    end else begin
      state_r     <= state_next_s;
      fsm_r       <= fsm_next_s;
      cnt_r       <= cnt_next_s;
      ptr_r       <= ptr_next_s;
      rsp_valid_r <= rsp_valid_next_s;
      rsp_data_r  <= rsp_data_next_s;
      busy_r      <= (fsm_next_s != RUN);
    end
  end

  assign Req_ready = grant_s;
  assign Rsp_valid = rsp_valid_r;
  assign Rsp_data  = rsp_data_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_xorshift_32_share_ctrl.sv
// Directed bench for xorshift_32_share_ctrl: vector table for arbitration and
// masking, plus sequences for seeding, warm-up and reset mid-stream.
module tb_xorshift_32_share_ctrl;

  localparam logic [31:0]  DEF_SEED = 32'h2545_F491;
  localparam logic [127:0] ALL1     = {128{1'b1}};
  localparam logic [127:0] MASKV    = {32'hFFFF_0000, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  logic         Clk;
  logic         Rst_n;
  logic         Seed_load;
  logic [31:0]  Seed_value;
  logic [3:0]   Req_valid;
  logic [127:0] Req_mask;
  logic [3:0]   Req_ready;
  logic [3:0]   Rsp_valid;
  logic [31:0]  Rsp_data;
  logic         Busy;

  logic         seed_load0;
  logic [31:0]  seed_value0;
  logic [3:0]   req_valid0;
  logic [127:0] req_mask0;
  logic [3:0]   req_ready0;
  logic [3:0]   rsp_valid0;
  logic [31:0]  rsp_data0;
  logic         busy0;

  xorshift_32_share_ctrl #(.NUM_REQ(4), .WARMUP_CYCLES(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Seed_load(Seed_load), .Seed_value(Seed_value),
    .Req_valid(Req_valid), .Req_mask(Req_mask), .Req_ready(Req_ready),
    .Rsp_valid(Rsp_valid), .Rsp_data(Rsp_data), .Busy(Busy)
  );

  xorshift_32_share_ctrl #(.NUM_REQ(4), .WARMUP_CYCLES(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Seed_load(seed_load0), .Seed_value(seed_value0),
    .Req_valid(req_valid0), .Req_mask(req_mask0), .Req_ready(req_ready0),
    .Rsp_valid(rsp_valid0), .Rsp_data(rsp_data0), .Busy(busy0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] mask;
    logic [3:0]   exp_ready;
  } vec_t;

  vec_t        vecs[17];
  int          checks;
  int          errors;
  logic [31:0] m_state;
  logic [31:0] last_exp;
  logic [31:0] got;
  logic [31:0] words[12];
  logic [3:0]  exp_seq[4];
  int          dups;

  function automatic logic [31:0] tb_step(input logic [31:0] x);
    logic [31:0] a, b;
    a = x ^ {x[18:0], 13'b0};
    b = a ^ {17'b0, a[31:17]};
    return b ^ {b[26:0], 5'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic advance_model(input int n);
    for (int i = 0; i < n; i++) m_state = tb_step(m_state);
  endtask

  // Called right after reset release or the seed-load edge.
  task automatic wait_warmup(input string name);
    for (int c = 0; c < 16; c++) begin
      chk({name, "_busy"}, 32'(Busy), 32'd1);
      chk({name, "_noready"}, 32'(Req_ready), 32'd0);
      @(negedge Clk);
    end
    chk({name, "_run"}, 32'(Busy), 32'd0);
  endtask

  task automatic do_cycle(input string name, input logic [3:0] valid, input logic [127:0] mask,
                          input logic [3:0] exp_ready, output logic [31:0] obs);
    int          gi;
    logic [31:0] exp_data;
    Req_valid = valid;
    Req_mask  = mask;
    #1;
    chk({name, "_ready"}, 32'(Req_ready), 32'(exp_ready));
    exp_data = last_exp;
    if (exp_ready != 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (exp_ready[i]) gi = i;
      m_state  = tb_step(m_state);
      exp_data = m_state & mask[32*gi +: 32];
    end
    @(negedge Clk);
    chk({name, "_rspv"}, 32'(Rsp_valid), 32'(exp_ready));
    chk({name, "_data"}, Rsp_data, exp_data);
    last_exp = exp_data;
    obs      = Rsp_data;
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 12; i++) begin
      vecs[i].valid     = 4'hF;
      vecs[i].mask      = ALL1;
      vecs[i].exp_ready = 4'b0001 << (i % 4);
    end
    vecs[12] = '{4'b0100, MASKV, 4'b0100};
    vecs[13] = '{4'b1111, ALL1,  4'b1000};
    vecs[14] = '{4'b0011, ALL1,  4'b0001};
    vecs[15] = '{4'b0000, ALL1,  4'b0000};
    vecs[16] = '{4'b0110, ALL1,  4'b0010};

    Rst_n = 1'b1; Seed_load = 1'b0; Seed_value = 32'h0; Req_valid = 4'h0; Req_mask = ALL1;
    seed_load0 = 1'b0; seed_value0 = 32'h0; req_valid0 = 4'h0; req_mask0 = ALL1;
    #1 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_rspv", 32'(Rsp_valid), 32'd0);
    chk("rst_data", Rsp_data, 32'd0);
    chk("rst_ready", 32'(Req_ready), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    Rst_n = 1'b1;
    m_state = DEF_SEED; last_exp = 32'h0;
    wait_warmup("boot");
    advance_model(16);

    // Zero warm-up instance, seed 1.
    seed_load0 = 1'b1; seed_value0 = 32'h0000_0001; req_valid0 = 4'b0001;
    #1 chk("z0_seed_noready", 32'(req_ready0), 32'd0);
    @(negedge Clk);
    seed_load0 = 1'b0;
    #1 chk("z0_ready", 32'(req_ready0), 32'b0001);
    chk("z0_busy", 32'(busy0), 32'd0);
    @(negedge Clk);
    req_valid0 = 4'b0000;
    chk("z0_rspv", 32'(rsp_valid0), 32'b0001);
    chk("z0_data", rsp_data0, 32'h0004_2021);

    // Table: fairness, masking, pointer movement, idle hold.
    for (int i = 0; i < 17; i++) begin
      do_cycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].mask, vecs[i].exp_ready, got);
      if (i < 12) words[i] = got;
      if (i == 12) chk("mask_le15", 32'(got <= 32'd15), 32'd1);
    end
    dups = 0;
    for (int a = 0; a < 12; a++)
      for (int b = a + 1; b < 12; b++)
        if (words[a] == words[b]) dups++;
    chk("fair_distinct_dups", 32'(dups), 32'd0);

    // Seed load with all requests pending; pointer stays at 2.
    Seed_load = 1'b1; Seed_value = 32'h1234_5678; Req_valid = 4'hF; Req_mask = ALL1;
    #1 chk("seed_noready", 32'(Req_ready), 32'd0);
    @(negedge Clk);
    Seed_load = 1'b0;
    m_state = 32'h1234_5678;
    wait_warmup("seed");
    advance_model(16);
    exp_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int k = 0; k < 4; k++) do_cycle($sformatf("pend%0d", k), 4'hF, ALL1, exp_seq[k], got);

    // Zero seed falls back to the default seed.
    Req_valid = 4'h0; Seed_load = 1'b1; Seed_value = 32'h0;
    @(negedge Clk);
    Seed_load = 1'b0;
    m_state = DEF_SEED;
    wait_warmup("zseed");
    advance_model(16);
    for (int k = 0; k < 4; k++) begin
      do_cycle($sformatf("zs%0d", k), 4'b0010, ALL1, 4'b0010, got);
      chk("zs_nonzero", 32'(got != 32'h0), 32'd1);
    end

    // Reset with a response in flight.
    Req_valid = 4'b0001; Req_mask = ALL1;
    #1 chk("mid_ready", 32'(Req_ready), 32'b0001);
    @(posedge Clk);
    #1;
    m_state = tb_step(m_state);
    chk("mid_rspv", 32'(Rsp_valid), 32'b0001);
    chk("mid_data", Rsp_data, m_state);
    Rst_n = 1'b0; Req_valid = 4'h0;
    #1;
    chk("mid_rst_rspv", 32'(Rsp_valid), 32'd0);
    chk("mid_rst_data", Rsp_data, 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    m_state = DEF_SEED; last_exp = 32'h0;
    wait_warmup("rerun");
    advance_model(16);
    do_cycle("post_rst", 4'hF, ALL1, 4'b0001, got);
    Req_valid = 4'h0;
    @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
